// File: rtl/w0rm_alu_pkg.sv
// Shared constants for the w0rm ALU dispatcher:
// opcodes, unit indices, flag bits and FSM states.
package w0rm_alu_pkg;

    localparam int UNIT_IDX_W = 3;

    localparam logic [3:0] OP_LOGIC_HI = 4'h3;
    localparam logic [3:0] OP_ADD      = 4'h4;
    localparam logic [3:0] OP_SUB      = 4'h5;
    localparam logic [3:0] OP_SHIFT_LO = 4'h6;
    localparam logic [3:0] OP_SHIFT_HI = 4'h9;
    localparam logic [3:0] OP_EXT_LO   = 4'hA;
    localparam logic [3:0] OP_EXT_HI   = 4'hB;
    localparam logic [3:0] OP_MUL      = 4'hC;
    localparam logic [3:0] OP_DIV_LO   = 4'hD;
    localparam logic [3:0] OP_DIV_HI   = 4'hE;
    localparam logic [3:0] OP_ILLEGAL  = 4'hF;

    localparam logic [UNIT_IDX_W-1:0] UNIT_LOGIC = 3'd0;
    localparam logic [UNIT_IDX_W-1:0] UNIT_ADD   = 3'd1;
    localparam logic [UNIT_IDX_W-1:0] UNIT_SHIFT = 3'd2;
    localparam logic [UNIT_IDX_W-1:0] UNIT_EXT   = 3'd3;
    localparam logic [UNIT_IDX_W-1:0] UNIT_MUL   = 3'd4;
    localparam logic [UNIT_IDX_W-1:0] UNIT_DIV   = 3'd5;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_NEG   = 1;
    localparam int FLAG_OVER  = 2;
    localparam int FLAG_CARRY = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/w0rm_alu_unit_decode.sv
// Opcode to ALU sub-unit decode.
// Purely combinational; 0xF flags an illegal op.
module w0rm_alu_unit_decode
    import w0rm_alu_pkg::*;
(
    input  logic [3:0]            i_opcode,
    output logic [UNIT_IDX_W-1:0] o_unit,
    output logic                  o_illegal
);

    // Range decode of the opcode space onto units
    always_comb begin
        o_unit    = UNIT_LOGIC;
        o_illegal = 1'b0;
        unique case (1'b1)
            (i_opcode <= OP_LOGIC_HI):
                o_unit = UNIT_LOGIC;
            (i_opcode >= OP_ADD && i_opcode <= OP_SUB):
                o_unit = UNIT_ADD;
            (i_opcode >= OP_SHIFT_LO && i_opcode <= OP_SHIFT_HI):
                o_unit = UNIT_SHIFT;
            (i_opcode >= OP_EXT_LO && i_opcode <= OP_EXT_HI):
                o_unit = UNIT_EXT;
            (i_opcode == OP_MUL):
                o_unit = UNIT_MUL;
            (i_opcode >= OP_DIV_LO && i_opcode <= OP_DIV_HI):
                o_unit = UNIT_DIV;
            (i_opcode == OP_ILLEGAL):
                o_illegal = 1'b1;
            default:
                o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/w0rm_alu_dispatch.sv
// ALU dispatcher: accepts one op, issues it to a sub-unit,
// waits (with timeout) for the result and holds it for writeback.
module w0rm_alu_dispatch
    import w0rm_alu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_UNITS      = 6,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [3:0]                      in_opcode,
    input  logic                            in_ext_8_16,
    input  logic [DATA_WIDTH-1:0]           in_data_a,
    input  logic [DATA_WIDTH-1:0]           in_data_b,
    output logic [NUM_UNITS-1:0]            unit_data_valid,
    output logic [3:0]                      unit_opcode,
    output logic                            unit_ext_8_16,
    output logic [DATA_WIDTH-1:0]           unit_data_a,
    output logic [DATA_WIDTH-1:0]           unit_data_b,
    input  logic [NUM_UNITS*DATA_WIDTH-1:0] unit_result,
    input  logic [NUM_UNITS-1:0]            unit_result_valid,
    input  logic [NUM_UNITS*4-1:0]          unit_result_flags,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH-1:0]           out_result,
    output logic [3:0]                      out_flags,
    output logic                            out_error,
    output logic                            busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    state_t                  r_state;
    logic [3:0]              r_opcode;
    logic                    r_ext;
    logic [DATA_WIDTH-1:0]   r_a;
    logic [DATA_WIDTH-1:0]   r_b;
    logic [UNIT_IDX_W-1:0]   r_unit;
    logic [NUM_UNITS-1:0]    r_udv;
    logic [DATA_WIDTH-1:0]   r_result;
    logic [3:0]              r_flags;
    logic                    r_error;
    logic [CNT_W-1:0]        r_cnt;

    logic [UNIT_IDX_W-1:0]   w_dec_unit;
    logic                    w_dec_illegal;
    logic [NUM_UNITS-1:0]    w_onehot;
    logic                    w_sel_valid;
    logic [DATA_WIDTH-1:0]   w_sel_result;
    logic [3:0]              w_sel_flags;

    w0rm_alu_unit_decode u_decode (
        .i_opcode  (in_opcode),
        .o_unit    (w_dec_unit),
        .o_illegal (w_dec_illegal)
    );

    assign w_onehot = {{(NUM_UNITS-1){1'b0}}, 1'b1} << w_dec_unit;

    // Pick the latched unit's result slice; other units are ignored
    always_comb begin
        w_sel_valid  = 1'b0;
        w_sel_result = '0;
        w_sel_flags  = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (r_unit == UNIT_IDX_W'(k)) begin
                w_sel_valid  = unit_result_valid[k];
                w_sel_result = unit_result[k*DATA_WIDTH +: DATA_WIDTH];
                w_sel_flags  = unit_result_flags[k*4 +: 4];
            end
        end
    end

    // Dispatch FSM with registered outputs and WAIT timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_opcode <= '0;
            r_ext    <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_unit   <= '0;
            r_udv    <= '0;
            r_result <= '0;
            r_flags  <= '0;
            r_error  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_opcode <= in_opcode;
                        r_ext    <= in_ext_8_16;
                        r_a      <= in_data_a;
                        r_b      <= in_data_b;
                        r_unit   <= w_dec_unit;
                        r_result <= '0;
                        r_flags  <= '0;
                        r_cnt    <= '0;
                        if (w_dec_illegal) begin
                            r_error <= 1'b1;
                            r_state <= ST_HOLD;
                        end else begin
                            r_error <= 1'b0;
                            r_udv   <= w_onehot;
                            r_state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_udv <= '0;
                    if (w_sel_valid) begin
                        r_result <= w_sel_result;
                        r_flags  <= w_sel_flags;
                        r_state  <= ST_HOLD;
                    end else begin
                        r_cnt   <= '0;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_sel_valid) begin
                        r_result <= w_sel_result;
                        r_flags  <= w_sel_flags;
                        r_state  <= ST_HOLD;
                    end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_error <= 1'b1;
                        r_state <= ST_HOLD;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready        = (r_state == ST_IDLE);
    assign busy            = (r_state != ST_IDLE);
    assign out_valid       = (r_state == ST_HOLD);
    assign out_result      = r_result;
    assign out_flags       = r_flags;
    assign out_error       = r_error;
    assign unit_data_valid = r_udv;
    assign unit_opcode     = r_opcode;
    assign unit_ext_8_16   = r_ext;
    assign unit_data_a     = r_a;
    assign unit_data_b     = r_b;

endmodule
